// File: rtl/my_keypad_pkg.sv
// Shared keypad types: scan FSM state encoding and key-code width helper.
package my_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_e;

  function automatic int unsigned kp_code_w(input int unsigned rows, input int unsigned cols);
    int unsigned n;
    n = rows * cols;
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/my_sync2.sv
// Generic two-flop synchronizer with async active-low reset to RST_VAL.
module my_sync2 #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/my_keypad_scan.sv
// Matrix keypad scanner: column strobe, whole-scan debounce, valid/ready key events.
// Optional KEYPAD_RELEASE_EN: debounced releases also emit an event with key_rel=1.
module my_keypad_scan
  import my_keypad_pkg::*;
#(
  parameter int unsigned  ROWS           = 4,
  parameter int unsigned  COLS           = 4,
  parameter int unsigned  SETTLE         = 1024,
  parameter int unsigned  DEBOUNCE_SCANS = 8,
  localparam int unsigned KW             = kp_code_w(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [COLS-1:0] col_drv,
  input  logic [ROWS-1:0] row_in,
  output logic [KW-1:0]   key_code,
  output logic            key_rel,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_down,
  output logic            key_ovf
);

  localparam int unsigned TW     = $clog2(SETTLE);
  localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned NW     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [NW-1:0] N_DONE = NW'(DEBOUNCE_SCANS);

  logic [ROWS-1:0] row_s;

  my_sync2 #(
    .W       (ROWS),
    .RST_VAL ({ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_in),
    .q_o   (row_s)
  );

  logic [TW-1:0]   t_q, t_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] col_drv_q;
  logic            sample, scan_end;

  // Column timer: rows sampled on the last settle cycle of each column.
  always_comb begin
    sample   = (t_q == TW'(SETTLE - 1));
    scan_end = sample && (col_q == CW'(COLS - 1));
    t_d      = sample ? '0 : t_q + TW'(1);
    col_d    = col_q;
    if (sample) begin
      col_d = scan_end ? '0 : col_q + CW'(1);
    end
  end

  logic [1:0]    hits_q;
  logic [KW-1:0] acc_code_q;
  logic [1:0]    col_hits, scan_hits;
  logic [2:0]    hit_sum;
  logic [KW-1:0] scan_code;
  logic          scan_vld;

  // Closed-key count saturates at 2 so that any multi-key scan reads as "none".
  always_comb begin
    col_hits  = 2'd0;
    scan_code = acc_code_q;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_s[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        scan_code = KW'(r * COLS + 32'(col_q));
      end
    end
    hit_sum   = 3'(hits_q) + 3'(col_hits);
    scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_vld  = (scan_hits == 2'd1);
  end

  kp_state_e     state_q;
  logic [KW-1:0] cand_q;
  logic [NW-1:0] n_q;
  logic          down_q;
  logic          press_acc, rel_acc;

  always_comb begin
    press_acc = 1'b0;
    rel_acc   = 1'b0;
    if (scan_end) begin
      case (state_q)
        SCAN:     press_acc = scan_vld && (DEBOUNCE_SCANS == 1);
        PRESS_DB: press_acc = scan_vld && (scan_code == cand_q) && ((n_q + NW'(1)) == N_DONE);
        HELD:     rel_acc   = !scan_vld && (DEBOUNCE_SCANS == 1);
        REL_DB:   rel_acc   = !scan_vld && ((n_q + NW'(1)) == N_DONE);
        default:  ;
      endcase
    end
  end

  logic          ev_c;
  logic [KW-1:0] ev_code_c;
  logic          load_c;

`ifdef KEYPAD_RELEASE_EN
  logic rel_q;

  assign ev_c      = press_acc || rel_acc;
  assign ev_code_c = rel_acc ? cand_q : scan_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b0;
    end else if (load_c) begin
      rel_q <= rel_acc;
    end
  end

  assign key_rel = rel_q;
`else
  assign ev_c      = press_acc;
  assign ev_code_c = scan_code;
  assign key_rel   = 1'b0;
`endif

  logic [KW-1:0] code_q;
  logic          valid_q, ovf_q;

  // A new event may only replace the slot when it is empty or being taken this cycle.
  assign load_c = ev_c && (!valid_q || key_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q        <= '0;
      col_q      <= '0;
      col_drv_q  <= '1;
      hits_q     <= '0;
      acc_code_q <= '0;
    end else begin
      t_q       <= t_d;
      col_q     <= col_d;
      col_drv_q <= ~(COLS'(1) << col_d);
      if (scan_end) begin
        hits_q     <= '0;
        acc_code_q <= '0;
      end else if (sample) begin
        hits_q     <= scan_hits;
        acc_code_q <= scan_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      cand_q  <= '0;
      n_q     <= '0;
      down_q  <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (scan_end) begin
        case (state_q)
          SCAN: begin
            if (scan_vld) begin
              cand_q <= scan_code;
              n_q    <= NW'(1);
              if (press_acc) begin
                down_q  <= 1'b1;
                state_q <= HELD;
              end else begin
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (scan_vld && (scan_code == cand_q)) begin
              n_q <= n_q + NW'(1);
              if (press_acc) begin
                down_q  <= 1'b1;
                state_q <= HELD;
              end
            end else begin
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (!scan_vld) begin
              n_q <= NW'(1);
              if (rel_acc) begin
                down_q  <= 1'b0;
                state_q <= SCAN;
              end else begin
                state_q <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (scan_vld) begin
              state_q <= HELD;
            end else begin
              n_q <= n_q + NW'(1);
              if (rel_acc) begin
                down_q  <= 1'b0;
                state_q <= SCAN;
              end
            end
          end
          default: state_q <= SCAN;
        endcase
      end

      ovf_q <= 1'b0;
      if (ev_c) begin
        if (load_c) begin
          code_q  <= ev_code_c;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && key_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign col_drv   = col_drv_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign key_ovf   = ovf_q;

endmodule

// File: tb/tb_my_keypad_scan.sv
// Scoreboard bench for my_keypad_scan: scan-level reference model, randomized key patterns.
module tb_my_keypad_scan;
  import my_keypad_pkg::*;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned DB     = 2;
  localparam int unsigned KW     = kp_code_w(ROWS, COLS);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [COLS-1:0] col_drv;
  logic [ROWS-1:0] row_in;
  logic [KW-1:0]   key_code;
  logic            key_rel, key_valid, key_down, key_ovf;
  logic            key_ready = 1'b0;
  logic [15:0]     keys = '0;

  my_keypad_scan #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_drv(col_drv), .row_in(row_in),
    .key_code(key_code), .key_rel(key_rel), .key_valid(key_valid),
    .key_ready(key_ready), .key_down(key_down), .key_ovf(key_ovf)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low while its column is strobed.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col_drv[c]) row_in[r] = 1'b0;
  end

  typedef struct packed {
    logic [KW-1:0] code;
    logic          rel;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0, n_pass = 0;
  int  ovf_seen = 0, ovf_exp = 0, ev_cnt = 0;

  int  m_cand = 0, m_run = 0, m_none = 0;
  bit  m_held = 0, m_drop = 0, have_prev = 0;
  logic [15:0] prev_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int scan_result(input logic [15:0] m);
    if ($countones(m) != 1) return -1;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_emit(input int code, input bit rel);
    if (exp_q.size() == 0) exp_q.push_back(ev_t'{code: KW'(code), rel: rel});
    else begin
      ovf_exp++;
      m_drop = 1'b1;
    end
  endtask

  // Scan-level debounce rules: r is the single closed key of one scan, or -1.
  task automatic model_scan(input int r);
    if (!m_held) begin
      if (m_run == 0) begin
        if (r >= 0) begin m_cand = r; m_run = 1; end
      end else if (r == m_cand) m_run++;
      else m_run = 0;
      if (m_run == int'(DB)) begin
        m_held = 1'b1; m_run = 0; m_none = 0;
        model_emit(m_cand, 1'b0);
      end
    end else begin
      if (r < 0) m_none++;
      else m_none = 0;
      if (m_none == int'(DB)) begin
        m_held = 1'b0; m_none = 0;
`ifdef KEYPAD_RELEASE_EN
        model_emit(m_cand, 1'b1);
`endif
      end
    end
  endtask

  task automatic model_reset();
    m_cand = 0; m_run = 0; m_none = 0; m_held = 1'b0; have_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_scan_start();
    logic [3:0] last;
    last = col_drv;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col_drv == 4'b1110 && last != 4'b1110) return;
      last = col_drv;
    end
    n_checks++;
    $display("FAIL scan_start: no column-0 strobe within 64 cycles, col_drv=%b", col_drv);
  endtask

  // One full scan: evaluate the previous scan in the model, then present this scan's keys.
  task automatic do_scan(input logic [15:0] m, input bit glitch, input bit rdy);
    wait_scan_start();
    m_drop = 1'b0;
    if (have_prev) model_scan(scan_result(prev_seen));
    check("key_down", key_down, m_held);
    check("key_ovf", key_ovf, m_drop);
    have_prev = 1'b1;
    prev_seen = m;
    key_ready = rdy;
    if (glitch) begin
      keys = '0;
      repeat (8) @(negedge clk);
      keys = m;
      repeat (4) @(negedge clk);
      keys = '0;
    end else begin
      keys = m;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every presented event must match the head of the expected queue.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (key_ovf) ovf_seen++;
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: code %0d rel %0d, none expected at %0t", key_code, key_rel, $time);
        end else begin
          check("ev_code", key_code, exp_q[0].code);
          check("ev_rel", key_rel, exp_q[0].rel);
          if (key_ready) begin
            void'(exp_q.pop_front());
            ev_cnt++;
          end
        end
      end else if (exp_q.size() != 0) begin
        n_checks++;
        $display("FAIL missing_event: key_valid 0, expected code %0d at %0t", exp_q[0].code, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ev0, ov0, a, b, sel;
    logic [3:0]  e;
    logic [15:0] cur;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col_drv", col_drv, 4'b1111);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_ovf", key_ovf, 0);
    check("rst_rel", key_rel, 0);
    check("rst_code", key_code, 0);
    rst_n = 1'b1;

    // Column strobe sequence
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_drv == 4'b1101) found = 1'b1;
    end
    check("col1_seen", found, 1);
    for (int i = 0; i < 16; i++) begin
      e = ~(4'(1) << ((1 + i / 4) % 4));
      check("col_drv_seq", col_drv, e);
      @(negedge clk);
    end

    // Stable press of code 6, then release
    ev0 = ev_cnt;
    repeat (4) do_scan(16'h0040, 1'b0, 1'b1);
    check("press6_code", key_code, 6);
    repeat (4) do_scan(16'h0000, 1'b0, 1'b1);
    settle();
`ifdef KEYPAD_RELEASE_EN
    check("press6_events", ev_cnt - ev0, 2);
`else
    check("press6_events", ev_cnt - ev0, 1);
`endif

    // Sub-scan glitch on code 6
    ev0 = ev_cnt;
    do_scan(16'h0040, 1'b1, 1'b1);
    repeat (3) do_scan(16'h0000, 1'b0, 1'b1);
    settle();
    check("glitch_events", ev_cnt - ev0, 0);
    check("glitch_down", key_down, 0);

    // Two keys in one row: ghost-suppressed
    ev0 = ev_cnt;
    repeat (5) do_scan(16'h0003, 1'b0, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0, 1'b1);
    settle();
    check("ghost_events", ev_cnt - ev0, 0);

    // Overflow while consumer stalls
    ev0 = ev_cnt;
    ov0 = ovf_seen;
    repeat (3) do_scan(16'h0020, 1'b0, 1'b0);
    repeat (3) do_scan(16'h0000, 1'b0, 1'b0);
    repeat (3) do_scan(16'h0200, 1'b0, 1'b0);
    repeat (3) do_scan(16'h0000, 1'b0, 1'b0);
    settle();
`ifdef KEYPAD_RELEASE_EN
    check("ovf_pulses", ovf_seen - ov0, 3);
`else
    check("ovf_pulses", ovf_seen - ov0, 1);
`endif
    check("stall_valid", key_valid, 1);
    check("stall_code", key_code, 5);
    repeat (2) do_scan(16'h0000, 1'b0, 1'b1);
    settle();
    check("drain_events", ev_cnt - ev0, 1);
    check("drain_valid", key_valid, 0);

    // Reset during press debounce, key stays closed
    repeat (2) do_scan(16'h0040, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_col_drv", col_drv, 4'b1111);
    check("midrst_valid", key_valid, 0);
    check("midrst_down", key_down, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    ev0 = ev_cnt;
    repeat (3) do_scan(16'h0040, 1'b0, 1'b1);
    settle();
    check("redetect_events", ev_cnt - ev0, 1);
    check("redetect_down", key_down, 1);
    repeat (4) do_scan(16'h0000, 1'b0, 1'b1);

    // Randomized key patterns and consumer stalls
    cur = '0;
    for (int s = 0; s < 80; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel <= 5) cur = '0;
      else if (sel >= 6 && sel <= 7) cur = 16'(1) << $urandom_range(0, 15);
      else if (sel == 8) begin
        a = int'($urandom_range(0, 15));
        b = (a + 1 + int'($urandom_range(0, 14))) % 16;
        cur = (16'(1) << a) | (16'(1) << b);
      end
      if (sel == 9) do_scan(16'(1) << $urandom_range(0, 15), 1'b1, ($urandom_range(0, 3) != 0));
      else do_scan(cur, 1'b0, ($urandom_range(0, 3) != 0));
    end
    repeat (DB + 3) do_scan(16'h0000, 1'b0, 1'b1);
    settle();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ovf_total", ovf_seen, ovf_exp);
    check("final_valid", key_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
